// File: rtl/inert_reader.sv
// inert_reader: configures an inertial sensor over a 16-bit SPI engine and then,
// each time the sensor raises its data-ready line, reads six bytes
// (pitch/roll/yaw, low byte then high byte) and presents them as one set.
//
// Ports
//   clk        system clock, all state changes on its rising edge
//   rst        synchronous active-high reset
//   INT        asynchronous data-ready level from the sensor
//   wrt        one-cycle pulse starting one SPI transaction
//   cmd        transaction word: bit15=1 read, [14:8] address, [7:0] write data
//   done       one-cycle pulse ending the outstanding transaction
//   rd_data    response word, only [7:0] used, valid while done is high
//   vld        one-cycle pulse: new ptch/roll/yaw available
//   ptch/roll/yaw  signed readings {high byte, low byte}
//   dbg_state  current FSM state (STARTUP=0, CFG=1, WAIT_INT=2, RD=3, UPDATE=4)
//
// Handshake: wrt is high for exactly one cycle per transaction and cmd holds its
// value from that cycle through the cycle done is seen. A done is honoured only
// while a transaction is outstanding (busy_q); any other done is ignored. The
// next wrt follows in the cycle after done, never earlier.
module inert_reader #(
  parameter int STARTUP_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        vld,
  output logic [15:0] ptch,
  output logic [15:0] roll,
  output logic [15:0] yaw,
  output logic [2:0]  dbg_state
);

  localparam int CW = (STARTUP_CYC > 1) ? $clog2(STARTUP_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STARTUP_CYC - 1);

  typedef enum logic [2:0] {
    ST_STARTUP  = 3'd0,
    ST_CFG      = 3'd1,
    ST_WAIT_INT = 3'd2,
    ST_RD       = 3'd3,
    ST_UPDATE   = 3'd4
  } state_t;

  // Configuration writes, issued in index order.
  function automatic logic [15:0] cfg_word(input logic [2:0] i);
    logic [15:0] w;
    case (i)
      3'd0:    w = 16'h0D02;
      3'd1:    w = 16'h1053;
      3'd2:    w = 16'h1150;
      3'd3:    w = 16'h1460;
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  // Read i targets register 0x22+i: ptch L/H, roll L/H, yaw L/H.
  function automatic logic [15:0] rd_word(input logic [2:0] i);
    logic [6:0] addr;
    addr = 7'h22 + {4'b0000, i};
    return {1'b1, addr, 8'h00};
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic            go_q, go_d;       // issue the first transaction of a state
  logic            busy_q, busy_d;   // a transaction is outstanding
  logic            wrt_q, wrt_d;
  logic [15:0]     cmd_q, cmd_d;
  logic            vld_q, vld_d;
  logic [15:0]     ptch_q, ptch_d;
  logic [15:0]     roll_q, roll_d;
  logic [15:0]     yaw_q, yaw_d;
  logic [7:0]      hold_q [6];
  logic [7:0]      hold_d [6];
  logic            int_ff1_q, int_ff1_d;
  logic            int_ff2_q, int_ff2_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    go_d      = 1'b0;
    busy_d    = busy_q;
    wrt_d     = 1'b0;
    cmd_d     = cmd_q;
    vld_d     = 1'b0;
    ptch_d    = ptch_q;
    roll_d    = roll_q;
    yaw_d     = yaw_q;
    hold_d    = hold_q;
    int_ff1_d = INT;
    int_ff2_d = int_ff1_q;

    case (state_q)
      ST_STARTUP: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_CFG;
          cnt_d   = '0;
          idx_d   = 3'd0;
          go_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_CFG: begin
        if (go_q) begin
          wrt_d  = 1'b1;
          cmd_d  = cfg_word(idx_q);
          busy_d = 1'b1;
        end else if (done && busy_q) begin
          busy_d = 1'b0;
          if (idx_q == 3'd3) begin
            state_d = ST_WAIT_INT;
            idx_d   = 3'd0;
          end else begin
            idx_d  = idx_q + 3'd1;
            wrt_d  = 1'b1;
            cmd_d  = cfg_word(idx_q + 3'd1);
            busy_d = 1'b1;
          end
        end
      end

      ST_WAIT_INT: begin
        if (int_ff2_q) begin
          state_d = ST_RD;
          idx_d   = 3'd0;
          go_d    = 1'b1;
          // Start each sequence from a clean holding register.
          for (int i = 0; i < 6; i++) hold_d[i] = 8'h00;
        end
      end

      ST_RD: begin
        if (go_q) begin
          wrt_d  = 1'b1;
          cmd_d  = rd_word(idx_q);
          busy_d = 1'b1;
        end else if (done && busy_q) begin
          busy_d = 1'b0;
          for (int i = 0; i < 6; i++) begin
            if (idx_q == 3'(i)) hold_d[i] = rd_data[7:0];
          end
          if (idx_q == 3'd5) begin
            // The yaw high byte arrives in this cycle, so take it straight
            // from rd_data; outputs and vld register together for UPDATE.
            state_d = ST_UPDATE;
            idx_d   = 3'd0;
            vld_d   = 1'b1;
            ptch_d  = {hold_q[1], hold_q[0]};
            roll_d  = {hold_q[3], hold_q[2]};
            yaw_d   = {rd_data[7:0], hold_q[4]};
          end else begin
            idx_d  = idx_q + 3'd1;
            wrt_d  = 1'b1;
            cmd_d  = rd_word(idx_q + 3'd1);
            busy_d = 1'b1;
          end
        end
      end

      ST_UPDATE: begin
        state_d = ST_WAIT_INT;
      end

      default: begin
        state_d = ST_STARTUP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_STARTUP;
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      go_q      <= 1'b0;
      busy_q    <= 1'b0;
      wrt_q     <= 1'b0;
      cmd_q     <= 16'h0000;
      vld_q     <= 1'b0;
      ptch_q    <= 16'h0000;
      roll_q    <= 16'h0000;
      yaw_q     <= 16'h0000;
      for (int i = 0; i < 6; i++) hold_q[i] <= 8'h00;
      int_ff1_q <= 1'b0;
      int_ff2_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      go_q      <= go_d;
      busy_q    <= busy_d;
      wrt_q     <= wrt_d;
      cmd_q     <= cmd_d;
      vld_q     <= vld_d;
      ptch_q    <= ptch_d;
      roll_q    <= roll_d;
      yaw_q     <= yaw_d;
      for (int i = 0; i < 6; i++) hold_q[i] <= hold_d[i];
      int_ff1_q <= int_ff1_d;
      int_ff2_q <= int_ff2_d;
    end
  end

  assign wrt       = wrt_q;
  assign cmd       = cmd_q;
  assign vld       = vld_q;
  assign ptch      = ptch_q;
  assign roll      = roll_q;
  assign yaw       = yaw_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_inert_reader.sv
// Directed bench for inert_reader. A responder answers each wrt with a done
// 8 cycles later, returning bytes from rd_bytes; a monitor logs every wrt/cmd
// and vld event with its cycle number and flags overlapping transactions and
// output changes outside vld.
module tb_inert_reader;
  localparam int STARTUP_CYC = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        int_in = 1'b0;
  logic        resp_done = 1'b0;
  logic        spur_done = 1'b0;
  logic        done;
  logic [15:0] rd_data = 16'h0000;
  logic        wrt, vld;
  logic [15:0] cmd, ptch, roll, yaw;
  logic [2:0]  dbg_state;

  assign done = resp_done | spur_done;

  inert_reader #(.STARTUP_CYC(STARTUP_CYC)) dut (
    .clk(clk), .rst(rst), .INT(int_in), .wrt(wrt), .cmd(cmd), .done(done),
    .rd_data(rd_data), .vld(vld), .ptch(ptch), .roll(roll), .yaw(yaw),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit outst = 1'b0;
  int ovl_cnt = 0;
  int chg_cnt = 0;
  int rsp_cnt = 0;
  int rsp_idx = 0;
  logic [7:0]  rd_bytes [6];
  logic [15:0] cmd_log[$];
  int          wcyc_log[$];
  int          vcyc_log[$];
  logic [47:0] vout_log[$];
  logic [47:0] prev_out = 48'h0;
  logic [15:0] exp_q[$];

  // Monitor + responder, 1ns after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (done) outst = 1'b0;
    resp_done = 1'b0;
    if (rsp_cnt != 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        resp_done = 1'b1;
        rd_data = {8'hEE, rd_bytes[rsp_idx]};
      end
    end
    if (wrt) begin
      if (outst) ovl_cnt++;
      outst = 1'b1;
      cmd_log.push_back(cmd);
      wcyc_log.push_back(cyc);
      rsp_cnt = 8;
      rsp_idx = cmd[15] ? int'(cmd[10:8]) - 2 : 0;
      if (rsp_idx < 0 || rsp_idx > 5) rsp_idx = 0;
    end
    if (vld) begin
      vcyc_log.push_back(cyc);
      vout_log.push_back({ptch, roll, yaw});
    end
    if (!vld && !rst && ({ptch, roll, yaw} != prev_out)) chg_cnt++;
    prev_out = {ptch, roll, yaw};
  end

  task automatic clear_logs();
    cmd_log.delete();
    wcyc_log.delete();
    vcyc_log.delete();
    vout_log.delete();
  endtask

  task automatic wait_wrts(input int n, input int budget, output bit ok);
    int k = 0;
    while (cmd_log.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (cmd_log.size() >= n);
  endtask

  task automatic wait_vlds(input int n, input int budget, output bit ok);
    int k = 0;
    while (vcyc_log.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (vcyc_log.size() >= n);
  endtask

  task automatic set_bytes(input logic [47:0] b);
    for (int i = 0; i < 6; i++) rd_bytes[i] = b[47 - 8*i -: 8];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    int_in = 1'b0;
    spur_done = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({wrt, vld} !== 2'b00) begin
      $display("FAIL reset_wrt_vld got %b want 00", {wrt, vld}); n_err++;
    end
    n_cmp++;
    if (cmd !== 16'h0000) begin
      $display("FAIL reset_cmd got %h want 0000", cmd); n_err++;
    end
    n_cmp++;
    if ({ptch, roll, yaw} !== 48'h0) begin
      $display("FAIL reset_outputs got %h want 0", {ptch, roll, yaw}); n_err++;
    end
    n_cmp++;
    if (dbg_state !== 3'd0) begin
      $display("FAIL reset_state got %0d want 0", dbg_state); n_err++;
    end
  endtask

  task automatic check_cfg(input string tag, input int rel);
    exp_q = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
    n_cmp++;
    if (cmd_log.size() != 4) begin
      $display("FAIL %s_wrt_count got %0d want 4", tag, cmd_log.size()); n_err++;
    end
    for (int i = 0; i < 4 && i < cmd_log.size(); i++) begin
      n_cmp++;
      if (cmd_log[i] !== exp_q[i]) begin
        $display("FAIL %s_cmd[%0d] got %h want %h", tag, i, cmd_log[i], exp_q[i]); n_err++;
      end
    end
    if (wcyc_log.size() > 0) begin
      n_cmp++;
      if (wcyc_log[0] - rel != STARTUP_CYC + 1) begin
        $display("FAIL %s_first_wrt got %0d want %0d", tag, wcyc_log[0] - rel, STARTUP_CYC + 1);
        n_err++;
      end
    end
    for (int i = 1; i < 4 && i < wcyc_log.size(); i++) begin
      n_cmp++;
      if (wcyc_log[i] - wcyc_log[i-1] != 9) begin
        $display("FAIL %s_gap[%0d] got %0d want 9", tag, i, wcyc_log[i] - wcyc_log[i-1]); n_err++;
      end
    end
    n_cmp++;
    if (vcyc_log.size() != 0) begin
      $display("FAIL %s_vld got %0d want 0", tag, vcyc_log.size()); n_err++;
    end
  endtask

  task automatic test_cfg();
    int rel;
    bit ok;
    clear_logs();
    @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    wait_wrts(4, 200, ok);
    n_cmp++;
    if (!ok) begin
      $display("FAIL cfg_timeout got %0d wrt want 4", cmd_log.size()); n_err++;
    end
    repeat (40) @(negedge clk);
    check_cfg("cfg", rel);
    n_cmp++;
    if (dbg_state !== 3'd2) begin
      $display("FAIL cfg_idle_state got %0d want 2", dbg_state); n_err++;
    end
    n_cmp++;
    if (vld !== 1'b0) begin
      $display("FAIL cfg_idle_vld got %b want 0", vld); n_err++;
    end
  endtask

  task automatic test_read();
    bit ok;
    clear_logs();
    set_bytes(48'h34_12_CD_AB_01_80);
    @(negedge clk);
    int_in = 1'b1;
    repeat (3) @(negedge clk);
    int_in = 1'b0;
    wait_vlds(1, 200, ok);
    n_cmp++;
    if (!ok) begin
      $display("FAIL read_timeout got %0d vld want 1", vcyc_log.size()); n_err++;
    end
    repeat (10) @(negedge clk);
    n_cmp++;
    if (cmd_log.size() != 6) begin
      $display("FAIL read_wrt_count got %0d want 6", cmd_log.size()); n_err++;
    end
    for (int i = 0; i < 6 && i < cmd_log.size(); i++) begin
      n_cmp++;
      if (cmd_log[i] !== 16'hA200 + 16'(i * 256)) begin
        $display("FAIL read_cmd[%0d] got %h want %h", i, cmd_log[i], 16'hA200 + 16'(i * 256));
        n_err++;
      end
    end
    n_cmp++;
    if (vcyc_log.size() != 1) begin
      $display("FAIL read_vld_count got %0d want 1", vcyc_log.size()); n_err++;
    end
    if (vout_log.size() > 0) begin
      n_cmp++;
      if (vout_log[0] !== 48'h1234_ABCD_8001) begin
        $display("FAIL read_values got %h want 1234abcd8001", vout_log[0]); n_err++;
      end
    end
    if (vcyc_log.size() > 0 && wcyc_log.size() >= 6) begin
      n_cmp++;
      if (vcyc_log[0] - wcyc_log[5] != 9) begin
        $display("FAIL read_latency got %0d want 9", vcyc_log[0] - wcyc_log[5]); n_err++;
      end
    end
    n_cmp++;
    if ({ptch, roll, yaw} !== 48'h1234_ABCD_8001) begin
      $display("FAIL read_hold got %h want 1234abcd8001", {ptch, roll, yaw}); n_err++;
    end
  endtask

  task automatic test_spurious_done();
    clear_logs();
    @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (cmd_log.size() != 0 || vcyc_log.size() != 0) begin
      $display("FAIL spur_activity got wrt=%0d vld=%0d want 0/0", cmd_log.size(), vcyc_log.size());
      n_err++;
    end
    n_cmp++;
    if ({ptch, roll, yaw} !== 48'h1234_ABCD_8001) begin
      $display("FAIL spur_outputs got %h want 1234abcd8001", {ptch, roll, yaw}); n_err++;
    end
    n_cmp++;
    if (dbg_state !== 3'd2) begin
      $display("FAIL spur_state got %0d want 2", dbg_state); n_err++;
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_logs();
    set_bytes(48'h11_22_33_44_55_66);
    @(negedge clk);
    int_in = 1'b1;
    wait_wrts(7, 300, ok);
    int_in = 1'b0;
    n_cmp++;
    if (!ok) begin
      $display("FAIL b2b_timeout_wrt got %0d want 7", cmd_log.size()); n_err++;
    end
    wait_vlds(2, 300, ok);
    n_cmp++;
    if (!ok) begin
      $display("FAIL b2b_timeout_vld got %0d want 2", vcyc_log.size()); n_err++;
    end
    repeat (30) @(negedge clk);
    n_cmp++;
    if (cmd_log.size() != 12) begin
      $display("FAIL b2b_wrt_count got %0d want 12", cmd_log.size()); n_err++;
    end
    for (int i = 0; i < 12 && i < cmd_log.size(); i++) begin
      n_cmp++;
      if (cmd_log[i] !== 16'hA200 + 16'((i % 6) * 256)) begin
        $display("FAIL b2b_cmd[%0d] got %h want %h", i, cmd_log[i], 16'hA200 + 16'((i % 6) * 256));
        n_err++;
      end
    end
    n_cmp++;
    if (vcyc_log.size() != 2) begin
      $display("FAIL b2b_vld_count got %0d want 2", vcyc_log.size()); n_err++;
    end
    for (int i = 0; i < vout_log.size(); i++) begin
      n_cmp++;
      if (vout_log[i] !== 48'h2211_4433_6655) begin
        $display("FAIL b2b_values[%0d] got %h want 221144336655", i, vout_log[i]); n_err++;
      end
    end
    if (vcyc_log.size() >= 2 && wcyc_log.size() >= 7) begin
      n_cmp++;
      if (wcyc_log[6] - vcyc_log[0] != 3) begin
        $display("FAIL b2b_restart got %0d want 3", wcyc_log[6] - vcyc_log[0]); n_err++;
      end
      n_cmp++;
      if (vcyc_log[1] - vcyc_log[0] != 57) begin
        $display("FAIL b2b_period got %0d want 57", vcyc_log[1] - vcyc_log[0]); n_err++;
      end
    end
    n_cmp++;
    if (chg_cnt != 0) begin
      $display("FAIL b2b_out_change got %0d want 0", chg_cnt); n_err++;
    end
  endtask

  task automatic test_reset_mid();
    int rel;
    bit ok;
    clear_logs();
    @(negedge clk);
    int_in = 1'b1;
    repeat (3) @(negedge clk);
    int_in = 1'b0;
    wait_wrts(3, 100, ok);
    n_cmp++;
    if (!ok) begin
      $display("FAIL rmid_timeout_rd got %0d want 3", cmd_log.size()); n_err++;
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    clear_logs();
    @(negedge clk);
    n_cmp++;
    if ({wrt, vld, cmd, ptch, roll, yaw} !== 66'h0) begin
      $display("FAIL rmid_outputs got %h want 0", {wrt, vld, cmd, ptch, roll, yaw}); n_err++;
    end
    n_cmp++;
    if (dbg_state !== 3'd0) begin
      $display("FAIL rmid_state got %0d want 0", dbg_state); n_err++;
    end
    rst = 1'b0;
    rel = cyc;
    wait_wrts(4, 200, ok);
    n_cmp++;
    if (!ok) begin
      $display("FAIL rmid_timeout_cfg got %0d want 4", cmd_log.size()); n_err++;
    end
    repeat (40) @(negedge clk);
    check_cfg("rmid", rel);
  endtask

  task automatic test_int_glitch();
    bit ok;
    clear_logs();
    @(negedge clk);
    #1 int_in = 1'b1;
    #2 int_in = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (cmd_log.size() != 0) begin
      $display("FAIL glitch_wrt got %0d want 0", cmd_log.size()); n_err++;
    end
    @(negedge clk);
    int_in = 1'b1;
    @(negedge clk);
    int_in = 1'b0;
    wait_wrts(2, 50, ok);
    n_cmp++;
    if (!ok) begin
      $display("FAIL pulse_timeout got %0d want 2", cmd_log.size()); n_err++;
    end
    @(negedge clk);
    int_in = 1'b1;
    repeat (2) @(negedge clk);
    int_in = 1'b0;
    wait_vlds(1, 200, ok);
    repeat (40) @(negedge clk);
    n_cmp++;
    if (cmd_log.size() != 6 || vcyc_log.size() != 1) begin
      $display("FAIL pulse_seq got wrt=%0d vld=%0d want 6/1", cmd_log.size(), vcyc_log.size());
      n_err++;
    end
    n_cmp++;
    if ({ptch, roll, yaw} !== 48'h2211_4433_6655) begin
      $display("FAIL pulse_values got %h want 221144336655", {ptch, roll, yaw}); n_err++;
    end
    n_cmp++;
    if (ovl_cnt != 0) begin
      $display("FAIL overlap got %0d want 0", ovl_cnt); n_err++;
    end
    n_cmp++;
    if (chg_cnt != 0) begin
      $display("FAIL out_change got %0d want 0", chg_cnt); n_err++;
    end
  endtask

  initial begin
    for (int i = 0; i < 6; i++) rd_bytes[i] = 8'h00;
    test_reset();
    test_cfg();
    test_read();
    test_spurious_done();
    test_back_to_back();
    test_reset_mid();
    test_int_glitch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
